// File: rtl/axis_argmax_collector_if.sv
// AXI-Stream bundle used on both sides of the argmax collector.
// Ports (modports):
//   master : drives tdata/tkeep/tvalid/tlast, observes tready
//   slave  : observes tdata/tkeep/tvalid/tlast, drives tready
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1. Once a master raises tvalid it holds tvalid, tdata, tkeep and
// tlast unchanged until that transfer edge; tready may change freely.
interface axis_argmax_collector_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tdata;
  logic              tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_argmax_collector.sv
// Argmax collector: consumes a packet of signed neuron outputs and emits a
// 2-beat result packet (beat 0 = winning index, beat 1 = winning value).
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   s_axis    : input stream (slave); tkeep=0 marks a null beat
//   m_axis    : result stream (master); beat 0 tdata = {ovf, zero pad, idx},
//               beat 1 tdata = max value with tlast=1
//   dbg_state : current FSM state (0=ACCUM, 1=SEND_IDX, 2=SEND_VAL)
module axis_argmax_collector #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  axis_argmax_collector_if.slave  s_axis,
  axis_argmax_collector_if.master m_axis,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    SEND_IDX = 2'd1,
    SEND_VAL = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_MAX  = '1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state, next_state;
  logic                tready_q;
  logic [IDX_W-1:0]    count;
  logic                sat;       // index IDX_MAX has already been handed out
  logic [DATA_W-1:0]   best_val;
  logic [IDX_W-1:0]    best_idx;
  logic                ovf;
  logic                any;

  logic                s_xfer;
  logic                m_hs;
  logic                better;
  logic [DATA_W-1:0]   idx_word;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tkeep;
  logic [DATA_W-1:0]   m_tdata;

  // tready is only ever 1 in ACCUM, so s_xfer implies state == ACCUM.
  assign s_xfer = s_axis.tvalid & tready_q;
  assign m_hs   = m_tvalid & m_axis.tready;
  assign better = !any || ($signed(s_axis.tdata) > $signed(best_val));

  always_comb begin
    idx_word                = '0;
    idx_word[IDX_W-1:0]     = best_idx;
    idx_word[DATA_W-1]      = ovf;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tkeep    = 1'b0;
    m_tdata    = '0;
    case (state)
      ACCUM: begin
        if (s_xfer && s_axis.tlast) next_state = SEND_IDX;
      end
      SEND_IDX: begin
        m_tvalid = 1'b1;
        m_tkeep  = 1'b1;
        m_tdata  = idx_word;
        if (m_axis.tready) next_state = SEND_VAL;
      end
      SEND_VAL: begin
        m_tvalid = 1'b1;
        m_tkeep  = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = best_val;
        if (m_axis.tready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tready_q <= 1'b0;
      count    <= '0;
      sat      <= 1'b0;
      best_val <= MOST_NEG;
      best_idx <= IDX_MAX;
      ovf      <= 1'b0;
      any      <= 1'b0;
    end else begin
      // Registered ready: follows the state we are entering.
      tready_q <= (next_state == ACCUM);

      if (s_xfer && s_axis.tkeep) begin
        // Strict compare keeps the earliest index on ties.
        if (better) begin
          best_val <= s_axis.tdata;
          best_idx <= count;
        end
        any <= 1'b1;
        if (sat) begin
          ovf <= 1'b1;
        end else if (count == IDX_MAX) begin
          sat <= 1'b1;
        end else begin
          count <= count + IDX_W'(1);
        end
      end

      if (state == SEND_VAL && m_hs) begin
        count    <= '0;
        sat      <= 1'b0;
        best_val <= MOST_NEG;
        best_idx <= IDX_MAX;
        ovf      <= 1'b0;
        any      <= 1'b0;
      end
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tlast  = m_tlast;
  assign m_axis.tkeep  = m_tkeep;
  assign m_axis.tdata  = m_tdata;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axis_argmax_collector.sv
module tb_axis_argmax_collector;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axis_argmax_collector_if #(.DATA_W(16)) s_if ();
  axis_argmax_collector_if #(.DATA_W(16)) m_if ();
  axis_argmax_collector_if #(.DATA_W(16)) s2_if ();
  axis_argmax_collector_if #(.DATA_W(16)) m2_if ();

  logic [1:0] dbg1;
  logic [1:0] dbg2;

  axis_argmax_collector #(.DATA_W(16), .IDX_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .dbg_state (dbg1)
  );

  axis_argmax_collector #(.DATA_W(16), .IDX_W(2)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .s_axis    (s2_if),
    .m_axis    (m2_if),
    .dbg_state (dbg2)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [15:0] d, input logic k, input logic l);
    int n;
    n = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: s_axis_tready=%b required 1", s_if.tready);
    end
    @(posedge clock); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send2_beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s2_if.tdata  = d;
    s2_if.tkeep  = 1'b1;
    s2_if.tlast  = l;
    s2_if.tvalid = 1'b1;
    while (!s2_if.tready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (s2_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL send2_timeout: s_axis_tready=%b required 1", s2_if.tready);
    end
    @(posedge clock); #1;
    s2_if.tvalid = 1'b0;
    s2_if.tlast  = 1'b0;
  endtask

  // Waits (bounded) for a result beat on dut, captures it, completes the handshake.
  task automatic get_beat(output logic [15:0] d, output logic l, output logic k, output logic ok);
    int n;
    n = 0;
    m_if.tready = 1'b1;
    while (!m_if.tvalid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    ok = m_if.tvalid;
    d  = m_if.tdata;
    l  = m_if.tlast;
    k  = m_if.tkeep;
    @(posedge clock); #1;
  endtask

  task automatic get2_beat(output logic [15:0] d, output logic l, output logic ok);
    int n;
    n = 0;
    while (!m2_if.tvalid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    ok = m2_if.tvalid;
    d  = m2_if.tdata;
    l  = m2_if.tlast;
    @(posedge clock); #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 ||
        m_if.tkeep !== 1'b0 || m_if.tdata !== 16'h0000 || dbg1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: tready=%b tvalid=%b tlast=%b tkeep=%b tdata=%h state=%0d required 0,0,0,0,0000,0",
               s_if.tready, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, dbg1);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: tready=%b required 0", s_if.tready);
    end
    @(posedge clock); #1;
    checks++;
    if (s_if.tready !== 1'b1 || s2_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: tready=%b/%b required 1/1", s_if.tready, s2_if.tready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic l, k, ok;
    send_beat(16'd5, 1'b1, 1'b0);
    send_beat(-16'sd3, 1'b1, 1'b0);
    send_beat(16'd17, 1'b1, 1'b0);
    send_beat(16'd2, 1'b1, 1'b1);
    checks++;
    if (m_if.tvalid !== 1'b1 || s_if.tready !== 1'b0 || dbg1 !== 2'd1) begin
      errors++;
      $display("FAIL basic_latency: tvalid=%b tready=%b state=%0d required 1,0,1",
               m_if.tvalid, s_if.tready, dbg1);
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0002 || l !== 1'b0 || k !== 1'b1) begin
      errors++;
      $display("FAIL basic_idx: valid=%b data=%h last=%b keep=%b required 1,0002,0,1", ok, d, l, k);
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0011 || l !== 1'b1 || k !== 1'b1) begin
      errors++;
      $display("FAIL basic_val: valid=%b data=%h last=%b keep=%b required 1,0011,1,1", ok, d, l, k);
    end
    checks++;
    if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_turnaround: tready=%b tvalid=%b required 1,0", s_if.tready, m_if.tvalid);
    end
  endtask

  task automatic test_tie();
    logic [15:0] d; logic l, k, ok;
    send_beat(16'd9, 1'b1, 1'b0);
    send_beat(16'd9, 1'b1, 1'b0);
    send_beat(16'd4, 1'b1, 1'b1);
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0000 || l !== 1'b0) begin
      errors++;
      $display("FAIL tie_idx: valid=%b data=%h last=%b required 1,0000,0", ok, d, l);
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0009 || l !== 1'b1) begin
      errors++;
      $display("FAIL tie_val: valid=%b data=%h last=%b required 1,0009,1", ok, d, l);
    end
  endtask

  task automatic test_negative_null();
    logic [15:0] d; logic l, k, ok;
    send_beat(-16'sd7, 1'b1, 1'b0);
    send_beat(-16'sd2, 1'b1, 1'b0);
    send_beat(16'h7FFF, 1'b0, 1'b0);
    send_beat(-16'sd100, 1'b1, 1'b1);
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0001 || l !== 1'b0) begin
      errors++;
      $display("FAIL neg_idx: valid=%b data=%h last=%b required 1,0001,0", ok, d, l);
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'hFFFE || l !== 1'b1) begin
      errors++;
      $display("FAIL neg_val: valid=%b data=%h last=%b required 1,fffe,1", ok, d, l);
    end
  endtask

  task automatic test_empty_stall();
    logic [15:0] d; logic l, k, ok;
    m_if.tready = 1'b0;
    send_beat(16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h00FF || m_if.tlast !== 1'b0 || s_if.tready !== 1'b0) begin
        errors++;
        $display("FAIL empty_idx_hold[%0d]: tvalid=%b tdata=%h tlast=%b tready=%b required 1,00ff,0,0",
                 i, m_if.tvalid, m_if.tdata, m_if.tlast, s_if.tready);
      end
      @(posedge clock); #1;
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h00FF || l !== 1'b0) begin
      errors++;
      $display("FAIL empty_idx: valid=%b data=%h last=%b required 1,00ff,0", ok, d, l);
    end
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h8000 || m_if.tlast !== 1'b1 || s_if.tready !== 1'b0) begin
        errors++;
        $display("FAIL empty_val_hold[%0d]: tvalid=%b tdata=%h tlast=%b tready=%b required 1,8000,1,0",
                 i, m_if.tvalid, m_if.tdata, m_if.tlast, s_if.tready);
      end
      @(posedge clock); #1;
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h8000 || l !== 1'b1) begin
      errors++;
      $display("FAIL empty_val: valid=%b data=%h last=%b required 1,8000,1", ok, d, l);
    end
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL empty_ready_return: tready=%b required 1", s_if.tready);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic l, ok;
    // Exactly 4 beats fits IDX_W=2: max at index 3, no overflow.
    send2_beat(16'd3, 1'b0);
    send2_beat(16'd1, 1'b0);
    send2_beat(16'd2, 1'b0);
    send2_beat(16'd6, 1'b1);
    get2_beat(d, l, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0003 || l !== 1'b0) begin
      errors++;
      $display("FAIL full_idx: valid=%b data=%h last=%b required 1,0003,0", ok, d, l);
    end
    get2_beat(d, l, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0006 || l !== 1'b1) begin
      errors++;
      $display("FAIL full_val: valid=%b data=%h last=%b required 1,0006,1", ok, d, l);
    end
    // Five beats: the fifth overflows and wins with the saturated index.
    send2_beat(16'd3, 1'b0);
    send2_beat(16'd1, 1'b0);
    send2_beat(16'd2, 1'b0);
    send2_beat(16'd4, 1'b0);
    send2_beat(16'd10, 1'b1);
    get2_beat(d, l, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h8003 || l !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idx: valid=%b data=%h last=%b required 1,8003,0", ok, d, l);
    end
    get2_beat(d, l, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h000A || l !== 1'b1) begin
      errors++;
      $display("FAIL ovf_val: valid=%b data=%h last=%b required 1,000a,1", ok, d, l);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d; logic l, k, ok;
    send_beat(16'd50, 1'b1, 1'b0);
    send_beat(16'd60, 1'b1, 1'b0);
    send_beat(16'd70, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tdata !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async: tready=%b tvalid=%b tdata=%h required 0,0,0000",
               s_if.tready, m_if.tvalid, m_if.tdata);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: tvalid=%b required 0", m_if.tvalid);
    end
    send_beat(16'd1, 1'b1, 1'b0);
    send_beat(16'd8, 1'b1, 1'b1);
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0001 || l !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idx: valid=%b data=%h last=%b required 1,0001,0", ok, d, l);
    end
    get_beat(d, l, k, ok);
    checks++;
    if (ok !== 1'b1 || d !== 16'h0008 || l !== 1'b1) begin
      errors++;
      $display("FAIL midreset_val: valid=%b data=%h last=%b required 1,0008,1", ok, d, l);
    end
  endtask

  initial begin
    s_if.tdata   = '0; s_if.tkeep  = 1'b0; s_if.tvalid  = 1'b0; s_if.tlast  = 1'b0;
    s2_if.tdata  = '0; s2_if.tkeep = 1'b0; s2_if.tvalid = 1'b0; s2_if.tlast = 1'b0;
    m_if.tready  = 1'b1;
    m2_if.tready = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_negative_null();
    test_empty_stall();
    test_overflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
